// File: rtl/ftdi_245fifo_pkg.sv
// Shared encodings for the FT60x 245-sync-FIFO device-side model.
package ftdi_245fifo_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } burst_state_t;

  localparam int ERR_UNDERRUN   = 0;
  localparam int ERR_OVERFLOW   = 1;
  localparam int ERR_CONTENTION = 2;
  localparam int ERR_W          = 3;

  function automatic int be_width(input int tdata_width);
    return tdata_width / 8;
  endfunction

endpackage

// File: rtl/ftdi_sync_fifo.sv
// Single-clock FIFO with combinational head, look-ahead count and a
// "mark last" port that sets the top bit of the most recently written entry.
module ftdi_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             usb_clk,
  input  logic             rstn_usbclk,
  input  logic             push,
  input  logic             pop,
  input  logic             mark_last,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [AW:0]      count_next,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, tail_ptr;
  logic             push_ok, pop_ok;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign tail_ptr   = wr_ptr - AW'(1);
  assign head       = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
    if (!rstn_usbclk) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge usb_clk) begin
    if (push_ok)   mem[wr_ptr] <= din;
    if (mark_last) mem[tail_ptr][WIDTH-1] <= 1'b1;
  end

endmodule

// File: rtl/ftdi_245fifo_device_model.sv
// FT60x device-side responder: H2F buffer fed from s_axis and read by the
// FPGA, F2H buffer written by the FPGA in bursts and drained on m_axis.
module ftdi_245fifo_device_model
  import ftdi_245fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 16
) (
  input  logic                            usb_clk,
  input  logic                            rstn_usbclk,
  output logic                            usb_txe_n,
  output logic                            usb_rxf_n,
  input  logic                            usb_wr_n,
  input  logic                            usb_rd_n,
  input  logic                            usb_oe_n,
  input  logic [TDATA_WIDTH-1:0]          usb_data_fpga,
  input  logic [be_width(TDATA_WIDTH)-1:0] usb_be_fpga,
  output logic [TDATA_WIDTH-1:0]          usb_data_dev,
  output logic [be_width(TDATA_WIDTH)-1:0] usb_be_dev,
  output logic                            usb_dev_drive,
  input  logic [TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [be_width(TDATA_WIDTH)-1:0] s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic [be_width(TDATA_WIDTH)-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [ERR_W-1:0]                err_flags
);

  localparam int BE_WIDTH = be_width(TDATA_WIDTH);
  localparam int HW       = TDATA_WIDTH + BE_WIDTH;
  localparam int AW       = $clog2(DEPTH);

  logic          alive;
  logic          h2f_push, h2f_pop, h2f_full, h2f_empty;
  logic [AW:0]   h2f_count_unused, h2f_count_next;
  logic [HW-1:0] h2f_head;
  logic          f2h_req, f2h_pop, f2h_full, f2h_empty_unused, mark_last;
  logic [AW:0]   f2h_count, f2h_count_next;
  logic [HW:0]   f2h_head;
  burst_state_t  state_q, state_d;

  assign usb_dev_drive = !usb_oe_n;
  assign s_axis_tready = alive && !h2f_full;
  assign h2f_push      = s_axis_tvalid && s_axis_tready;
  assign h2f_pop       = !usb_oe_n && !usb_rd_n;
  assign f2h_req       = !usb_wr_n && usb_oe_n;
  assign f2h_pop       = m_axis_tvalid && m_axis_tready;

  ftdi_sync_fifo #(.WIDTH(HW), .DEPTH(DEPTH)) u_h2f (
    .usb_clk    (usb_clk),
    .rstn_usbclk(rstn_usbclk),
    .push       (h2f_push),
    .pop        (h2f_pop),
    .mark_last  (1'b0),
    .din        ({s_axis_tdata, s_axis_tkeep}),
    .full       (h2f_full),
    .empty      (h2f_empty),
    .count      (h2f_count_unused),
    .count_next (h2f_count_next),
    .head       (h2f_head)
  );

  ftdi_sync_fifo #(.WIDTH(HW+1), .DEPTH(DEPTH)) u_f2h (
    .usb_clk    (usb_clk),
    .rstn_usbclk(rstn_usbclk),
    .push       (f2h_req),
    .pop        (f2h_pop),
    .mark_last  (mark_last),
    .din        ({1'b0, usb_data_fpga, usb_be_fpga}),
    .full       (f2h_full),
    .empty      (f2h_empty_unused),
    .count      (f2h_count),
    .count_next (f2h_count_next),
    .head       (f2h_head)
  );

  assign usb_data_dev = h2f_head[HW-1:BE_WIDTH];
  assign usb_be_dev   = h2f_head[BE_WIDTH-1:0];
  assign m_axis_tdata = f2h_head[HW-1:BE_WIDTH];
  assign m_axis_tkeep = f2h_head[BE_WIDTH-1:0];
  assign m_axis_tlast = f2h_head[HW];

  // The newest entry is held back until the burst closes and its last bit is known.
  assign m_axis_tvalid = (f2h_count >= (AW+1)'(2)) ||
                         (f2h_count == (AW+1)'(1) && state_q == S_IDLE);

  always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
    if (!rstn_usbclk) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (f2h_req && !f2h_full) state_d = S_BURST;
      S_BURST: if (usb_wr_n)             state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mark_last = (state_q == S_BURST) && usb_wr_n;
  end

  always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
    if (!rstn_usbclk) begin
      alive     <= 1'b0;
      usb_txe_n <= 1'b1;
      usb_rxf_n <= 1'b1;
      err_flags <= '0;
    end else begin
      alive     <= 1'b1;
      usb_txe_n <= (f2h_count_next == (AW+1)'(DEPTH));
      usb_rxf_n <= (h2f_count_next == '0);
      if (h2f_pop && h2f_empty)       err_flags[ERR_UNDERRUN]   <= 1'b1;
      if (f2h_req && f2h_full)        err_flags[ERR_OVERFLOW]   <= 1'b1;
      if (!usb_wr_n && !usb_oe_n)     err_flags[ERR_CONTENTION] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftdi_245fifo_device_model.sv
// Directed test-plan sequences plus randomized traffic, checked every cycle
// against a queue-based model of both buffers and the burst rule.
module tb_ftdi_245fifo_device_model;

  localparam int TW    = 32;
  localparam int BW    = TW / 8;
  localparam int DEPTH = 16;

  logic          usb_clk = 1'b0;
  logic          rstn_usbclk = 1'b0;
  logic          usb_txe_n, usb_rxf_n, usb_dev_drive;
  logic          usb_wr_n = 1'b1, usb_rd_n = 1'b1, usb_oe_n = 1'b1;
  logic [TW-1:0] usb_data_fpga = '0, usb_data_dev;
  logic [BW-1:0] usb_be_fpga = '0, usb_be_dev;
  logic [TW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [BW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic          s_axis_tvalid = 1'b0, s_axis_tready;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready = 1'b0;
  logic [2:0]    err_flags;

  ftdi_245fifo_device_model #(.TDATA_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .usb_clk(usb_clk), .rstn_usbclk(rstn_usbclk),
    .usb_txe_n(usb_txe_n), .usb_rxf_n(usb_rxf_n),
    .usb_wr_n(usb_wr_n), .usb_rd_n(usb_rd_n), .usb_oe_n(usb_oe_n),
    .usb_data_fpga(usb_data_fpga), .usb_be_fpga(usb_be_fpga),
    .usb_data_dev(usb_data_dev), .usb_be_dev(usb_be_dev), .usb_dev_drive(usb_dev_drive),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .err_flags(err_flags)
  );

  always #5 usb_clk = ~usb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [TW-1:0] d;
    logic [BW-1:0] be;
    logic          last;
  } ent_t;

  ent_t     h2f_q[$];
  ent_t     f2h_q[$];
  bit       m_burst = 0, m_alive = 0, m_txe_n = 1, m_rxf_n = 1;
  bit [2:0] m_err = '0;
  bit       mh_push, mh_pop, mf_push, mf_pop, m_mark;
  ent_t     m_e;

  function automatic bit mdl_s_tready();
    return m_alive && (h2f_q.size() < DEPTH);
  endfunction

  function automatic bit mdl_m_tvalid();
    return (f2h_q.size() >= 2) || (f2h_q.size() == 1 && !m_burst);
  endfunction

  initial forever begin
    @(posedge usb_clk or negedge rstn_usbclk);
    if (!rstn_usbclk) begin
      h2f_q.delete(); f2h_q.delete();
      m_burst = 0; m_alive = 0; m_txe_n = 1; m_rxf_n = 1; m_err = '0;
    end else begin
      mh_pop  = !usb_oe_n && !usb_rd_n && h2f_q.size() > 0;
      mh_push = s_axis_tvalid && mdl_s_tready();
      mf_pop  = mdl_m_tvalid() && m_axis_tready;
      mf_push = !usb_wr_n && usb_oe_n && f2h_q.size() < DEPTH;
      m_mark  = m_burst && usb_wr_n;
      if (!usb_oe_n && !usb_rd_n && h2f_q.size() == 0)   m_err[0] = 1;
      if (!usb_wr_n && usb_oe_n && f2h_q.size() == DEPTH) m_err[1] = 1;
      if (!usb_wr_n && !usb_oe_n)                         m_err[2] = 1;
      if (m_mark && f2h_q.size() > 0) begin
        m_e = f2h_q[f2h_q.size()-1];
        m_e.last = 1'b1;
        f2h_q[f2h_q.size()-1] = m_e;
      end
      if (mh_pop) void'(h2f_q.pop_front());
      if (mf_pop) void'(f2h_q.pop_front());
      if (mh_push) h2f_q.push_back('{d: s_axis_tdata, be: s_axis_tkeep, last: 1'b0});
      if (mf_push) f2h_q.push_back('{d: usb_data_fpga, be: usb_be_fpga, last: 1'b0});
      if (m_burst && usb_wr_n)   m_burst = 0;
      else if (!m_burst && mf_push) m_burst = 1;
      m_txe_n = (f2h_q.size() == DEPTH);
      m_rxf_n = (h2f_q.size() == 0);
      m_alive = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge usb_clk) begin
    cmp("txe_n", usb_txe_n, m_txe_n);
    cmp("rxf_n", usb_rxf_n, m_rxf_n);
    cmp("s_tready", s_axis_tready, mdl_s_tready());
    cmp("m_tvalid", m_axis_tvalid, mdl_m_tvalid());
    cmp("dev_drive", usb_dev_drive, !usb_oe_n);
    cmp("data_dev", usb_data_dev, h2f_q.size() > 0 ? h2f_q[0].d : '0);
    cmp("be_dev", usb_be_dev, h2f_q.size() > 0 ? h2f_q[0].be : '0);
    cmp("err_flags", err_flags, m_err);
    if (mdl_m_tvalid()) begin
      cmp("m_tdata", m_axis_tdata, f2h_q[0].d);
      cmp("m_tkeep", m_axis_tkeep, f2h_q[0].be);
      cmp("m_tlast", m_axis_tlast, f2h_q[0].last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  logic [TW-1:0] got_d [$];
  logic          got_l [$];

  task automatic collect(input int want, input int bound);
    got_d.delete(); got_l.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < bound && got_d.size() < want; i++) begin
      if (m_axis_tvalid) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      tick();
    end
    m_axis_tready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    cmp("rst_txe_n", usb_txe_n, 1);
    cmp("rst_rxf_n", usb_rxf_n, 1);
    cmp("rst_tready", s_axis_tready, 0);
    cmp("rst_tvalid", m_axis_tvalid, 0);
    cmp("rst_tlast", m_axis_tlast, 0);
    cmp("rst_data_dev", usb_data_dev, 0);
    cmp("rst_err", err_flags, 0);
    rstn_usbclk = 1'b1;
    tick();
    cmp("rel_txe_n", usb_txe_n, 0);
    cmp("rel_rxf_n", usb_rxf_n, 1);

    // H2F: load 0x11..0x44, then read them back
    for (int i = 0; i < 4; i++) begin
      s_axis_tdata = TW'((i + 1) * 32'h11);
      s_axis_tkeep = 4'hF;
      s_axis_tvalid = 1'b1;
      tick();
      if (i == 0) begin
        cmp("h2f_first_rxf", usb_rxf_n, 0);
        cmp("h2f_first_head", usb_data_dev, 32'h11);
      end
    end
    s_axis_tvalid = 1'b0;
    usb_oe_n = 1'b0; usb_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp("h2f_read_seq", usb_data_dev, TW'((i + 1) * 32'h11));
      tick();
    end
    cmp("h2f_rxf_after", usb_rxf_n, 1);
    cmp("h2f_err", err_flags, 0);
    usb_oe_n = 1'b1; usb_rd_n = 1'b1;
    tick();

    // F2H: 3-word burst
    usb_be_fpga = 4'hF;
    for (int i = 0; i < 3; i++) begin
      usb_data_fpga = 32'hA0 + TW'(i);
      usb_wr_n = 1'b0;
      tick();
      if (i == 0) cmp("burst_withheld", m_axis_tvalid, 0);
    end
    usb_wr_n = 1'b1;
    tick();
    collect(3, 10);
    cmp("burst_beats", got_d.size(), 3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      cmp("burst_data", got_d[i], 32'hA0 + TW'(i));
      cmp("burst_last", got_l[i], (i == 2));
    end

    // F2H overflow: 17 writes into 16 entries
    for (int i = 0; i < 17; i++) begin
      usb_data_fpga = 32'h100 + TW'(i);
      usb_wr_n = 1'b0;
      tick();
      if (i == 14) cmp("ovf_txe_15", usb_txe_n, 0);
      if (i == 15) cmp("ovf_txe_16", usb_txe_n, 1);
    end
    cmp("ovf_err", err_flags[1], 1);
    usb_wr_n = 1'b1;
    tick();
    collect(16, 40);
    cmp("ovf_beats", got_d.size(), 16);
    if (got_d.size() == 16) begin
      cmp("ovf_first", got_d[0], 32'h100);
      cmp("ovf_lastdata", got_d[15], 32'h10F);
      cmp("ovf_tlast", got_l[15], 1);
      cmp("ovf_tlast_mid", got_l[7], 0);
    end
    tick();
    cmp("ovf_drained", m_axis_tvalid, 0);

    // underrun then contention
    usb_oe_n = 1'b0; usb_rd_n = 1'b0;
    tick();
    cmp("underrun_err", err_flags[0], 1);
    cmp("underrun_rxf", usb_rxf_n, 1);
    usb_rd_n = 1'b1; usb_wr_n = 1'b0;
    tick();
    cmp("contention_err", err_flags[2], 1);
    usb_oe_n = 1'b1; usb_wr_n = 1'b1;
    tick();
    cmp("contention_nopush", m_axis_tvalid, 0);

    // reset mid-burst
    s_axis_tdata = 32'h55; s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      usb_data_fpga = 32'h200 + TW'(i);
      usb_wr_n = 1'b0;
      tick();
    end
    rstn_usbclk = 1'b0;
    #1;
    cmp("rstmid_txe_n", usb_txe_n, 1);
    cmp("rstmid_rxf_n", usb_rxf_n, 1);
    cmp("rstmid_tvalid", m_axis_tvalid, 0);
    cmp("rstmid_err", err_flags, 0);
    usb_wr_n = 1'b1;
    tick();
    rstn_usbclk = 1'b1;
    tick();
    cmp("rstmid_rel_txe", usb_txe_n, 0);
    cmp("rstmid_empty", m_axis_tvalid, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = TW'($urandom);
      s_axis_tkeep  = BW'($urandom_range(0, 15));
      usb_data_fpga = TW'($urandom);
      usb_be_fpga   = BW'($urandom_range(0, 15));
      usb_wr_n      = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      usb_oe_n      = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      usb_rd_n      = 1'($urandom_range(0, 1));
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (c == 1500) rstn_usbclk = 1'b0;
      if (c == 1502) rstn_usbclk = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
